// File: rtl/i2c_target_pkg.sv
// ============================================================================
// Module  : i2c_target_pkg
// Brief   : Shared state encoding, bus levels and counter widths for i2c_target.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_target_pkg;

  typedef enum logic [3:0] {
    k_idle     = 4'd0,
    k_addr     = 4'd1,
    k_addr_ack = 4'd2,
    k_rx       = 4'd3,
    k_rx_ack   = 4'd4,
    k_tx       = 4'd5,
    k_tx_ack   = 4'd6,
    k_ignore   = 4'd7
  } state_e;

  localparam logic c_ACK_LVL   = 1'b0;
  localparam logic c_NACK_LVL  = 1'b1;
  localparam int   c_BIT_CNT_W = 3;
  localparam int   c_HOLD_W    = 8;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
// Module  : i2c_bus_sync
// Brief   : Two-flop synchronisers on SCL/SDA plus edge and START/STOP detect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  // Idle bus level is high, so everything resets to 1 to avoid false events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign sda_s     = sda_sync_q;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
// Module  : i2c_target
// Brief   : I2C target responder; I2C_TARGET_CLOCK_STRETCH_EN adds SCL stretching.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h42,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  ,
  input  logic       rx_ack
`endif
);

  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e                 state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [c_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [c_HOLD_W-1:0]    hold_q, hold_d;
  logic                   pend_q, pend_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_load_q, tx_load_d;
  logic                   busy_q, busy_d;
  logic                   ack_drv_q, ack_drv_d;
  logic                   sched_en, sched_val, bus_clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= k_idle;
      shift_q    <= 8'h00;
      bit_cnt_q  <= '0;
      hold_q     <= '0;
      pend_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      ack_drv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
      ack_drv_q  <= ack_drv_d;
    end
  end

  // SDA is never changed directly: a falling edge schedules a level in pend_q
  // and the hold counter applies it once it counts down to 1.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
    ack_drv_d  = ack_drv_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    sched_en   = 1'b0;
    sched_val  = 1'b0;
    bus_clear  = 1'b0;
    pend_d     = pend_q;
    hold_d     = (hold_q != '0) ? hold_q - 8'd1 : hold_q;
    sda_oe_d   = (hold_q == 8'd1) ? pend_q : sda_oe_q;

    if (start_det) begin
      state_d   = k_addr;
      bit_cnt_d = '0;
      ack_drv_d = 1'b0;
      bus_clear = 1'b1;
    end else if (stop_det) begin
      state_d   = k_idle;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
      bus_clear = 1'b1;
    end else begin
      case (state_q)
        k_addr: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_q[6:0] == ADDRESS) begin
                state_d   = k_addr_ack;
                busy_d    = 1'b1;
                ack_drv_d = 1'b0;
              end else begin
                state_d = k_ignore;
                busy_d  = 1'b0;
              end
            end
          end
        end
        // First fall starts the ACK, second fall ends it.
        k_addr_ack: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              ack_drv_d = 1'b1;
              sched_en  = 1'b1;
              sched_val = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              sched_en  = 1'b1;
              if (shift_q[0] == 1'b0) begin
                state_d   = k_rx;
                sched_val = 1'b0;
              end else begin
                state_d   = k_tx;
                tx_load_d = 1'b1;
                shift_d   = tx_data;
                sched_val = ~tx_data[7];
              end
            end
          end
        end
        k_rx: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              state_d    = k_rx_ack;
              ack_drv_d  = 1'b0;
            end
          end
        end
        k_rx_ack: begin
          if (scl_fall) begin
            sched_en = 1'b1;
            if (!ack_drv_q) begin
              ack_drv_d = 1'b1;
              sched_val = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              sched_val = 1'b0;
              state_d   = k_rx;
            end
          end
        end
        k_tx: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (scl_fall) begin
            sched_en = 1'b1;
            if (bit_cnt_q == '0) begin
              sched_val = 1'b0;
              state_d   = k_tx_ack;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sched_val = ~shift_q[6];
            end
          end
        end
        k_tx_ack: begin
          if (scl_rise) begin
            if (sda_s == c_NACK_LVL) begin
              state_d = k_ignore;
              busy_d  = 1'b0;
            end
          end else if (scl_fall) begin
            state_d   = k_tx;
            tx_load_d = 1'b1;
            shift_d   = tx_data;
            sched_en  = 1'b1;
            sched_val = ~tx_data[7];
          end
        end
        default: ;
      endcase
    end

    if (bus_clear) begin
      hold_d   = '0;
      sda_oe_d = 1'b0;
    end else if (sched_en) begin
      hold_d = c_HOLD_LOAD;
      pend_d = sched_val;
    end
  end

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  logic       str_wait_q;
  logic [1:0] str_cnt_q;
  logic       str_wait_set;

  assign str_wait_set = (state_q == k_rx_ack) && (state_d == k_rx);

  // Hold SCL after an RX ACK until the user acknowledges, and briefly after
  // each tx_load so tx_data can settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      str_wait_q <= 1'b0;
      str_cnt_q  <= 2'd0;
    end else if (start_det || stop_det) begin
      str_wait_q <= 1'b0;
      str_cnt_q  <= 2'd0;
    end else begin
      if (str_wait_set) begin
        str_wait_q <= 1'b1;
      end else if (rx_ack) begin
        str_wait_q <= 1'b0;
      end
      if (tx_load_d) begin
        str_cnt_q <= 2'd2;
      end else if (str_cnt_q != 2'd0) begin
        str_cnt_q <= str_cnt_q - 2'd1;
      end
    end
  end

  assign scl_oe = str_wait_q | (str_cnt_q != 2'd0);
`else
  assign scl_oe = 1'b0;
`endif

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
// Module  : tb_i2c_target
// Brief   : Directed bench: open-drain bus model driving i2c_target transactions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_target;
  import i2c_target_pkg::*;

  localparam int c_Q    = 10;
  localparam int c_H    = 20;
  localparam int c_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       scl_oe, sda_oe, rx_valid, tx_load, busy;
  logic [7:0] rx_data;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  logic       rx_ack = 1'b1;
`endif

  wire scl_line = scl_drv & ~scl_oe;
  wire sda_line = sda_drv & ~sda_oe;

  i2c_target #(.ADDRESS(7'h42), .HOLD_CYCLES(c_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_line),
    .sda_in   (sda_line),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .busy     (busy)
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    ,
    .rx_ack   (rx_ack)
`endif
  );

  always #5 clk = ~clk;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  rxv_cnt  = 0;
  int  txl_cnt  = 0;
  int  oe_cnt   = 0;
  time t_fall   = 0;
  time hold_dly = 0;

  always @(posedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (tx_load)  txl_cnt++;
    if (sda_oe)   oe_cnt++;
  end

  always @(negedge scl_line) t_fall = $time;
  always @(posedge sda_oe) hold_dly = $time - t_fall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; wclk(c_Q);
    scl_drv = 1'b1; wclk(c_H);
    sda_drv = 1'b0; wclk(c_H);
    scl_drv = 1'b0; wclk(c_Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; wclk(c_Q);
    scl_drv = 1'b1; wclk(c_H);
    sda_drv = 1'b1; wclk(c_H);
  endtask

  task automatic write_bit(input logic b);
    sda_drv = b;    wclk(c_Q);
    scl_drv = 1'b1; wclk(c_H);
    scl_drv = 1'b0; wclk(c_Q);
  endtask

  task automatic read_bit(output logic b, output logic oe);
    sda_drv = 1'b1; wclk(c_Q);
    scl_drv = 1'b1; wclk(c_H / 2);
    b  = sda_line;
    oe = sda_oe;
    wclk(c_H / 2);
    scl_drv = 1'b0; wclk(c_Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_b, output logic ack_oe);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_b, ack_oe);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b, oe;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b, oe);
      d = {d[6:0], b};
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ab, aoe;
    logic [7:0] rd;
    int         rxv0, txl0, oe0;

    // Reset values
    wclk(3);
    check("rst_sda_oe",   32'(sda_oe),        32'h0);
    check("rst_scl_oe",   32'(scl_oe),        32'h0);
    check("rst_rx_data",  32'(rx_data),       32'h00);
    check("rst_rx_valid", 32'(rx_valid),      32'h0);
    check("rst_tx_load",  32'(tx_load),       32'h0);
    check("rst_busy",     32'(busy),          32'h0);
    check("rst_state",    32'(dut.state_q),   32'(k_idle));
    reset = 1'b0;
    wclk(3);

    // Write: address 0x42/W, data 0xA5
    rxv0 = rxv_cnt;
    bus_start();
    check("wr_state_addr", 32'(dut.state_q), 32'(k_addr));
    write_byte(8'h84, ab, aoe);
    check("wr_addr_ack_line", 32'(ab),  32'h0);
    check("wr_addr_ack_oe",   32'(aoe), 32'h1);
    check("wr_busy",          32'(busy), 32'h1);
    check("wr_hold_delay",    32'(hold_dly), 32'((3 + c_HOLD) * 10 - 5));
    write_byte(8'hA5, ab, aoe);
    check("wr_data_ack_line", 32'(ab),  32'h0);
    check("wr_data_ack_oe",   32'(aoe), 32'h1);
    check("wr_rx_data",       32'(rx_data), 32'hA5);
    check("wr_rx_valid_cnt",  32'(rxv_cnt - rxv0), 32'd1);
    bus_stop();
    check("wr_busy_after_stop", 32'(busy),        32'h0);
    check("wr_state_idle",      32'(dut.state_q), 32'(k_idle));
    check("wr_sda_released",    32'(sda_oe),      32'h0);

    // Read: address 0x42/R, one byte 0x3C, controller NACK
    tx_data = 8'h3C;
    txl0 = txl_cnt;
    bus_start();
    write_byte(8'h85, ab, aoe);
    check("rd_addr_ack", 32'(ab), 32'h0);
    read_byte(rd);
    check("rd_data",        32'(rd), 32'h3C);
    check("rd_tx_load_cnt", 32'(txl_cnt - txl0), 32'd1);
    write_bit(1'b1);
    check("rd_state_ignore", 32'(dut.state_q), 32'(k_ignore));
    check("rd_busy_nack",    32'(busy),        32'h0);
    bus_stop();
    check("rd_state_idle", 32'(dut.state_q), 32'(k_idle));

    // Address mismatch: 0x90 never acknowledged, following byte ignored
    oe0  = oe_cnt;
    rxv0 = rxv_cnt;
    bus_start();
    write_byte(8'h90, ab, aoe);
    check("mm_nack",  32'(ab),   32'h1);
    check("mm_busy",  32'(busy), 32'h0);
    check("mm_state", 32'(dut.state_q), 32'(k_ignore));
    write_byte(8'h55, ab, aoe);
    check("mm_nack2",      32'(ab), 32'h1);
    check("mm_oe_never",   32'(oe_cnt - oe0),   32'd0);
    check("mm_no_rxvalid", 32'(rxv_cnt - rxv0), 32'd0);
    bus_stop();

    // Repeated START after 4 data bits, then a two-byte read (ACK, NACK)
    rxv0 = rxv_cnt;
    txl0 = txl_cnt;
    bus_start();
    write_byte(8'h84, ab, aoe);
    check("rs_addr_ack", 32'(ab), 32'h0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_start();
    check("rs_state_addr", 32'(dut.state_q), 32'(k_addr));
    tx_data = 8'hC3;
    write_byte(8'h85, ab, aoe);
    check("rs_readdr_ack", 32'(ab), 32'h0);
    read_byte(rd);
    check("rs_rd0", 32'(rd), 32'hC3);
    tx_data = 8'h5A;
    write_bit(1'b0);
    read_byte(rd);
    check("rs_rd1", 32'(rd), 32'h5A);
    write_bit(1'b1);
    check("rs_no_rxvalid",  32'(rxv_cnt - rxv0), 32'd0);
    check("rs_tx_load_cnt", 32'(txl_cnt - txl0), 32'd2);
    bus_stop();

    // Asynchronous reset while driving the RX ACK
    bus_start();
    write_byte(8'h84, ab, aoe);
    for (int i = 7; i >= 0; i--) write_bit(1'b1);
    check("ar_state_rxack", 32'(dut.state_q), 32'(k_rx_ack));
    check("ar_sda_oe_pre",  32'(sda_oe),      32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_sda_oe",  32'(sda_oe),      32'h0);
    check("ar_scl_oe",  32'(scl_oe),      32'h0);
    check("ar_state",   32'(dut.state_q), 32'(k_idle));
    check("ar_busy",    32'(busy),        32'h0);
    wclk(2);
    reset = 1'b0;
    wclk(2);
    bus_stop();
    check("ar_state_final", 32'(dut.state_q), 32'(k_idle));

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    // Clock stretch until rx_ack rises
    rx_ack = 1'b0;
    bus_start();
    write_byte(8'h84, ab, aoe);
    write_byte(8'h11, ab, aoe);
    check("cs_rx_data",   32'(rx_data), 32'h11);
    check("cs_scl_held0", 32'(scl_oe),  32'h1);
    wclk(40);
    check("cs_scl_held1", 32'(scl_oe),  32'h1);
    rx_ack = 1'b1;
    #1;
    check("cs_scl_held2", 32'(scl_oe),  32'h1);
    wclk(1);
    check("cs_scl_released", 32'(scl_oe), 32'h0);
    bus_stop();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
